// File: rtl/pipe_ctrl_chain.sv
// Chain of pipeline control registers (ID..WB) carrying valid, control word and PC tag,
// with decode-stage stall/bubble insertion, flush, and saturating bubble/retire counters.
module pipe_ctrl_chain #(
  parameter int CW     = 16,
  parameter int PCW    = 8,
  parameter int STAGES = 4,
  parameter int CNTW   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [CW-1:0]         in_ctrl,
  input  logic [PCW-1:0]        in_pc,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  in_ready,
  output logic [STAGES-1:0]     stage_valid,
  output logic [STAGES*CW-1:0]  stage_ctrl,
  output logic [STAGES*PCW-1:0] stage_pc,
  output logic [CNTW-1:0]       bubble_cnt,
  output logic [CNTW-1:0]       retire_cnt
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  assign in_ready = ~stall;

  // Invalid slots always carry a zero control word and PC, so consumers never need to gate.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
      stage_ctrl  <= '0;
      stage_pc    <= '0;
      bubble_cnt  <= '0;
      retire_cnt  <= '0;
    end else begin
      if (flush) begin
        stage_valid[0]      <= 1'b0;
        stage_ctrl[0 +: CW] <= '0;
        stage_pc[0 +: PCW]  <= '0;
      end else if (!stall) begin
        stage_valid[0]      <= in_valid;
        stage_ctrl[0 +: CW] <= in_valid ? in_ctrl : '0;
        stage_pc[0 +: PCW]  <= in_valid ? in_pc : '0;
      end

      if (stall) begin
        stage_valid[1]       <= 1'b0;
        stage_ctrl[CW +: CW] <= '0;
        stage_pc[PCW +: PCW] <= '0;
      end else begin
        stage_valid[1]       <= stage_valid[0];
        stage_ctrl[CW +: CW] <= stage_ctrl[0 +: CW];
        stage_pc[PCW +: PCW] <= stage_pc[0 +: PCW];
      end

      for (int k = 2; k < STAGES; k++) begin
        stage_valid[k]         <= stage_valid[k-1];
        stage_ctrl[k*CW +: CW] <= stage_ctrl[(k-1)*CW +: CW];
        stage_pc[k*PCW +: PCW] <= stage_pc[(k-1)*PCW +: PCW];
      end

      if (stall && (bubble_cnt != CNT_MAX))
        bubble_cnt <= bubble_cnt + CNT_ONE;
      if (stage_valid[STAGES-1] && (retire_cnt != CNT_MAX))
        retire_cnt <= retire_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: default build plus CNTW=4 and STAGES=2/CW=8 builds.
module tb_pipe_ctrl_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, stall, flush, in_ready;
  logic [15:0] in_ctrl;
  logic [7:0]  in_pc;
  logic [3:0]  stage_valid;
  logic [63:0] stage_ctrl;
  logic [31:0] stage_pc;
  logic [15:0] bubble_cnt, retire_cnt;

  logic        c_valid, c_stall, c_flush, c_ready;
  logic [15:0] c_ctrl;
  logic [7:0]  c_pc;
  logic [3:0]  c_stage_valid;
  logic [63:0] c_stage_ctrl;
  logic [31:0] c_stage_pc;
  logic [3:0]  c_bubble, c_retire;

  logic        s_valid, s_stall, s_flush, s_ready;
  logic [7:0]  s_ctrl, s_pc;
  logic [1:0]  s_stage_valid;
  logic [15:0] s_stage_ctrl, s_stage_pc;
  logic [15:0] s_bubble, s_retire;

  int errors = 0;
  int checks = 0;

  pipe_ctrl_chain dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_pc(in_pc),
    .stall(stall), .flush(flush), .in_ready(in_ready), .stage_valid(stage_valid),
    .stage_ctrl(stage_ctrl), .stage_pc(stage_pc), .bubble_cnt(bubble_cnt),
    .retire_cnt(retire_cnt)
  );

  pipe_ctrl_chain #(.CNTW(4)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_valid), .in_ctrl(c_ctrl), .in_pc(c_pc),
    .stall(c_stall), .flush(c_flush), .in_ready(c_ready), .stage_valid(c_stage_valid),
    .stage_ctrl(c_stage_ctrl), .stage_pc(c_stage_pc), .bubble_cnt(c_bubble),
    .retire_cnt(c_retire)
  );

  pipe_ctrl_chain #(.STAGES(2), .CW(8)) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ctrl(s_ctrl), .in_pc(s_pc),
    .stall(s_stall), .flush(s_flush), .in_ready(s_ready), .stage_valid(s_stage_valid),
    .stage_ctrl(s_stage_ctrl), .stage_pc(s_stage_pc), .bubble_cnt(s_bubble),
    .retire_cnt(s_retire)
  );

  function automatic logic [15:0] ctrl_at(input int k);
    return stage_ctrl[k*16 +: 16];
  endfunction

  function automatic logic [7:0] pc_at(input int k);
    return stage_pc[k*8 +: 8];
  endfunction

  // Drive the main DUT's inputs, then advance one edge and settle for sampling.
  task automatic applyStimulus(input logic v, input logic [15:0] c, input logic [7:0] p,
                               input logic st, input logic fl);
    in_valid = v;
    in_ctrl  = c;
    in_pc    = p;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_ctrl = '0; in_pc = '0; stall = 0; flush = 0;
    c_valid = 0; c_ctrl = '0; c_pc = '0; c_stall = 0; c_flush = 0;
    s_valid = 0; s_ctrl = '0; s_pc = '0; s_stall = 0; s_flush = 0;

    // Reset overrides valid input and stall.
    applyStimulus(1'b1, 16'hFFFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("rst_valid", 64'(stage_valid), 64'h0);
    checkOutput("rst_ctrl", stage_ctrl, 64'h0);
    checkOutput("rst_pc", 64'(stage_pc), 64'h0);
    checkOutput("rst_bubble", 64'(bubble_cnt), 64'h0);
    checkOutput("rst_retire", 64'(retire_cnt), 64'h0);
    checkOutput("rst_ready_stall", 64'(in_ready), 64'h0);
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("rst_ready", 64'(in_ready), 64'h1);
    reset = 1'b0;

    // Six back-to-back instructions.
    applyStimulus(1'b1, 16'h0101, 8'h00, 1'b0, 1'b0);
    checkOutput("b2b_s0_ctrl", 64'(ctrl_at(0)), 64'h0101);
    checkOutput("b2b_s0_valid", 64'(stage_valid), 64'h1);
    for (int i = 1; i < 4; i++)
      applyStimulus(1'b1, 16'(16'h0101 + i), 8'(4 * i), 1'b0, 1'b0);
    checkOutput("b2b_s3_ctrl", 64'(ctrl_at(3)), 64'h0101);
    checkOutput("b2b_s3_pc", 64'(pc_at(3)), 64'h0);
    checkOutput("b2b_s0_ctrl4", 64'(ctrl_at(0)), 64'h0104);
    checkOutput("b2b_valid_full", 64'(stage_valid), 64'hF);
    checkOutput("b2b_retire4", 64'(retire_cnt), 64'h0);
    for (int i = 4; i < 6; i++)
      applyStimulus(1'b1, 16'(16'h0101 + i), 8'(4 * i), 1'b0, 1'b0);
    checkOutput("b2b_retire6e", 64'(retire_cnt), 64'h2);
    checkOutput("b2b_s1_pc", 64'(pc_at(1)), 64'h10);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("b2b_retire9e", 64'(retire_cnt), 64'h5);
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("b2b_retire10e", 64'(retire_cnt), 64'h6);
    checkOutput("b2b_drained", 64'(stage_valid), 64'h0);
    checkOutput("b2b_s3_ctrl_zero", 64'(ctrl_at(3)), 64'h0);

    // Two-cycle stall with 0x00A3 held in stage 0; inputs during stall are ignored.
    applyStimulus(1'b1, 16'h00A3, 8'h08, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h5555, 8'h44, 1'b1, 1'b0);
    checkOutput("stl1_s0_ctrl", 64'(ctrl_at(0)), 64'h00A3);
    checkOutput("stl1_s1_valid", 64'(stage_valid[1]), 64'h0);
    checkOutput("stl1_s1_ctrl", 64'(ctrl_at(1)), 64'h0);
    checkOutput("stl1_ready", 64'(in_ready), 64'h0);
    applyStimulus(1'b1, 16'h5555, 8'h44, 1'b1, 1'b0);
    checkOutput("stl2_s0_ctrl", 64'(ctrl_at(0)), 64'h00A3);
    checkOutput("stl2_s0_pc", 64'(pc_at(0)), 64'h08);
    checkOutput("stl2_s1_valid", 64'(stage_valid[1]), 64'h0);
    checkOutput("stl2_bubble", 64'(bubble_cnt), 64'h2);
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("stl_rel_s1_ctrl", 64'(ctrl_at(1)), 64'h00A3);
    checkOutput("stl_rel_s1_pc", 64'(pc_at(1)), 64'h08);
    checkOutput("stl_rel_valid", 64'(stage_valid), 64'h2);
    checkOutput("stl_rel_bubble", 64'(bubble_cnt), 64'h2);

    // Flush kills only the incoming instruction.
    applyStimulus(1'b1, 16'h0BBB, 8'h30, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1234, 8'h34, 1'b0, 1'b1);
    checkOutput("fl_s0_valid", 64'(stage_valid[0]), 64'h0);
    checkOutput("fl_s0_ctrl", 64'(ctrl_at(0)), 64'h0);
    checkOutput("fl_s1_ctrl", 64'(ctrl_at(1)), 64'h0BBB);
    checkOutput("fl_s1_pc", 64'(pc_at(1)), 64'h30);
    checkOutput("fl_valid", 64'(stage_valid), 64'hA);
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("fl_retire", 64'(retire_cnt), 64'h7);

    // Stall and flush together with stage 0 valid.
    applyStimulus(1'b1, 16'h0CCC, 8'h40, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0DDD, 8'h44, 1'b1, 1'b1);
    checkOutput("sf_valid", 64'(stage_valid), 64'h0);
    checkOutput("sf_s0_ctrl", 64'(ctrl_at(0)), 64'h0);
    checkOutput("sf_s1_ctrl", 64'(ctrl_at(1)), 64'h0);
    checkOutput("sf_bubble", 64'(bubble_cnt), 64'h3);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("sf_retire", 64'(retire_cnt), 64'h8);

    // Reset with four instructions in flight.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 16'(16'h0E01 + i), 8'(8'h50 + 4 * i), 1'b0, 1'b0);
    checkOutput("mid_full", 64'(stage_valid), 64'hF);
    checkOutput("mid_s3_ctrl", 64'(ctrl_at(3)), 64'h0E01);
    reset = 1'b1;
    applyStimulus(1'b1, 16'h0E05, 8'h60, 1'b0, 1'b0);
    checkOutput("mid_rst_valid", 64'(stage_valid), 64'h0);
    checkOutput("mid_rst_ctrl", stage_ctrl, 64'h0);
    checkOutput("mid_rst_pc", 64'(stage_pc), 64'h0);
    checkOutput("mid_rst_retire", 64'(retire_cnt), 64'h0);
    checkOutput("mid_rst_bubble", 64'(bubble_cnt), 64'h0);
    reset = 1'b0;

    // CNTW=4 build: bubble counter saturates at 15.
    c_stall = 1'b1;
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("sat_14", 64'(c_bubble), 64'hE);
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("sat_15", 64'(c_bubble), 64'hF);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("sat_20", 64'(c_bubble), 64'hF);
    c_stall = 1'b0;

    // STAGES=2, CW=8 build: two-edge latency to the last stage.
    s_valid = 1'b1; s_ctrl = 8'h5A; s_pc = 8'h12;
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    s_valid = 1'b0; s_ctrl = 8'h00; s_pc = 8'h00;
    checkOutput("s2_s0_ctrl", 64'(s_stage_ctrl[7:0]), 64'h5A);
    checkOutput("s2_valid0", 64'(s_stage_valid), 64'h1);
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("s2_s1_ctrl", 64'(s_stage_ctrl[15:8]), 64'h5A);
    checkOutput("s2_s1_pc", 64'(s_stage_pc[15:8]), 64'h12);
    checkOutput("s2_valid1", 64'(s_stage_valid), 64'h2);
    checkOutput("s2_retire_pre", 64'(s_retire), 64'h0);
    applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    checkOutput("s2_retire", 64'(s_retire), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
